// File: rtl/fixed_weight_error_gen.sv
// fixed_weight_error_gen
//   Builds a length-n error vector of Hamming weight exactly t for the
//   Classic McEliece encryptor.  Random candidate positions arrive on
//   idx_in. Out-of-range and duplicate positions are dropped. Each new
//   position sets one bit in an E_DEPTH x e_width RAM.  The encryptor
//   reads the finished vector word by word through a second RAM port.
//
// Ports
//   clk        single clock
//   rst        synchronous active-high reset
//   start      one-cycle request to begin generation (ignored while busy)
//   idx_in     random candidate position (m bits)
//   idx_valid  idx_in is valid
//   idx_ready  block is accepting an index (only in S_FETCH)
//   rd_e       encryptor read enable
//   e_addr     encryptor word address
//   error      registered error word, mem[e_addr] one cycle after rd_e
//   busy       generation in progress
//   done       one-cycle pulse when weight t is reached
//
// Handshake: an index transfers on every rising edge where
// idx_valid && idx_ready. The producer holds idx_in stable while valid is
// high and not yet accepted. idx_ready never depends on idx_valid.

module fixed_weight_error_gen #(
    parameter int parameter_set = 1,
    parameter int n = (parameter_set == 1) ? 3488 :
                      (parameter_set == 2) ? 4608 :
                      (parameter_set == 3) ? 6688 :
                      (parameter_set == 4) ? 6960 : 8192,
    parameter int m = (parameter_set == 1) ? 12 : 13,
    parameter int t = (parameter_set == 1) ? 64  :
                      (parameter_set == 2) ? 96  :
                      (parameter_set == 3) ? 128 :
                      (parameter_set == 4) ? 119 : 128,
    parameter int e_width = 160,
    localparam int E_DEPTH = (n + e_width - 1) / e_width,
    localparam int EAW = $clog2(E_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [m-1:0]       idx_in,
    input  logic               idx_valid,
    output logic               idx_ready,
    input  logic               rd_e,
    input  logic [EAW-1:0]     e_addr,
    output logic [e_width-1:0] error,
    output logic               busy,
    output logic               done
);

    localparam int AW = EAW - 1;             // internal RAM address width
    localparam int BW = $clog2(e_width);     // bit-within-word index width
    localparam int CW = $clog2(t) + 1;       // weight counter width

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_READ,
        S_MODIFY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_q, clr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [m-1:0]      idx_q, idx_d;

    logic [e_width-1:0] mem [E_DEPTH];
    logic [e_width-1:0] rdata_a_q;
    logic [e_width-1:0] error_q;

    logic               we_a;
    logic               re_a;
    logic [AW-1:0]      wa_addr;
    logic [e_width-1:0] wa_data;

    logic [31:0]        idx_ext;
    logic [AW-1:0]      tgt_word;
    logic [BW-1:0]      tgt_bit;
    logic [e_width-1:0] tgt_mask;

    // Position p lives in word p/e_width at bit e_width-1-(p%e_width), so
    // the lowest position of each word sits in the MSB (shifted out first).
    always_comb begin
        idx_ext  = 32'(idx_q);
        tgt_word = AW'(idx_ext / 32'(e_width));
        tgt_bit  = BW'(32'(e_width - 1) - (idx_ext % 32'(e_width)));
        tgt_mask = {{(e_width-1){1'b0}}, 1'b1} << tgt_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            clr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_a      = 1'b0;
        re_a      = 1'b0;
        wa_addr   = '0;
        wa_data   = '0;
        idx_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    clr_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                busy    = 1'b1;
                we_a    = 1'b1;
                wa_addr = clr_q;
                if (clr_q == AW'(E_DEPTH - 1)) begin
                    state_d = S_FETCH;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                idx_ready = 1'b1;
                if (idx_valid) begin
                    idx_d = idx_in;
                    // Out-of-range candidates cost one cycle and are dropped.
                    if (32'(idx_in) < 32'(n)) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                busy    = 1'b1;
                re_a    = 1'b1;
                state_d = S_MODIFY;
            end
            S_MODIFY: begin
                busy = 1'b1;
                if (rdata_a_q[tgt_bit]) begin
                    // Duplicate position: weight unchanged.
                    state_d = S_FETCH;
                end else begin
                    we_a    = 1'b1;
                    wa_addr = tgt_word;
                    wa_data = rdata_a_q | tgt_mask;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(t - 1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port A: internal read-modify-write. RAM contents survive reset; every
    // start re-clears all words before new positions are accepted.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[wa_addr] <= wa_data;
        end
        if (re_a) begin
            rdata_a_q <= mem[tgt_word];
        end
    end

    // Port B: encryptor read, served in every state. Addresses beyond the
    // last word return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= '0;
        end else if (rd_e) begin
            if (e_addr < EAW'(E_DEPTH)) begin
                error_q <= mem[e_addr[AW-1:0]];
            end else begin
                error_q <= '0;
            end
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_fixed_weight_error_gen.sv
module tb_fixed_weight_error_gen;

    localparam int EW    = 160;
    localparam int DEPTH = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [11:0]   idx_in;
    logic          idx_valid;
    logic          idx_ready;
    logic          rd_e;
    logic [5:0]    e_addr;
    logic [EW-1:0] error;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_mem [DEPTH];
    logic [EW-1:0] got     [DEPTH];

    fixed_weight_error_gen #(.parameter_set(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .idx_in    (idx_in),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .rd_e      (rd_e),
        .e_addr    (e_addr),
        .error     (error),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
    endtask

    task automatic model_set(input int p);
        exp_mem[p / EW][EW - 1 - (p % EW)] = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait for idx_ready, present one index, and check how ready behaves
    // after the transfer (stays high for a rejected index).
    task automatic send(input int v, input bit reject);
        int k;
        k = 0;
        while (!idx_ready && k < 200) begin
            step();
            k++;
        end
        if (!idx_ready) begin
            chk($sformatf("ready_timeout_%0d", v), {159'b0, idx_ready}, 160'd1);
        end else begin
            idx_in    = 12'(v);
            idx_valid = 1'b1;
            step();
            idx_valid = 1'b0;
            if (reject) chk($sformatf("reject_ready_%0d", v), {159'b0, idx_ready}, 160'd1);
        end
    endtask

    task automatic wait_done(output int cycles_waited);
        int k;
        k = 0;
        while (!done && k < 400) begin
            step();
            k++;
        end
        cycles_waited = k;
        chk("done_seen", {159'b0, done}, 160'd1);
        step();
        chk("done_one_cycle", {159'b0, done}, 160'd0);
        chk("busy_after_done", {159'b0, busy}, 160'd0);
    endtask

    task automatic rd(input int a, output logic [EW-1:0] d);
        rd_e   = 1'b1;
        e_addr = 6'(a);
        step();
        rd_e   = 1'b0;
        d      = error;
    endtask

    // Sweep all words, compare each against the model and the total weight.
    task automatic verify_all(input string tag);
        int pop;
        logic [EW-1:0] d;
        pop = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, d);
            got[a] = d;
            pop += $countones(d);
            chk($sformatf("%s_word%0d", tag, a), d, exp_mem[a]);
        end
        chk($sformatf("%s_popcount", tag), EW'(pop), 160'd64);
        // error must hold while rd_e is low
        e_addr = 6'd0;
        step();
        chk($sformatf("%s_hold", tag), error, exp_mem[DEPTH-1]);
    endtask

    initial begin
        int  w;
        time t0;
        logic [EW-1:0] d;

        rst = 1'b1; start = 1'b0; idx_in = '0; idx_valid = 1'b0;
        rd_e = 1'b0; e_addr = '0;
        step(); step(); step();
        chk("rst_busy",  {159'b0, busy},      160'd0);
        chk("rst_ready", {159'b0, idx_ready}, 160'd0);
        chk("rst_done",  {159'b0, done},      160'd0);
        chk("rst_error", error,               160'd0);
        rst = 1'b0;
        step();

        // Run 1: positions 0..63 back-to-back, timed from start.
        model_clear();
        for (int i = 0; i < 64; i++) model_set(i);
        start = 1'b1;
        t0 = $time;
        step();
        start = 1'b0;
        chk("start_busy",      {159'b0, busy},      160'd1);
        chk("clear_not_ready", {159'b0, idx_ready}, 160'd0);
        for (int i = 0; i < 64; i++) send(i, 1'b0);
        w = 0;
        while (!done && w < 400) begin
            step();
            w++;
        end
        // 1 edge to capture start, 22 clear cycles, 64 x 3 cycles per index.
        chk("run1_cycles", EW'(($time - t0) / 10), EW'(1 + 22 + 64 * 3));
        chk("run1_done", {159'b0, done}, 160'd1);
        step();
        chk("run1_done_pulse", {159'b0, done}, 160'd0);
        chk("run1_busy_low",   {159'b0, busy}, 160'd0);
        rd(0, d);
        chk("run1_word0_const", d, {64'hFFFF_FFFF_FFFF_FFFF, 96'h0});
        verify_all("run1");

        // Run 2: out-of-range 3488 and 4095 interleaved with 64 distinct positions.
        model_clear();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                step(); step();
                chk("run2_busy_before_last", {159'b0, busy}, 160'd1);
                chk("run2_no_early_done",    {159'b0, done}, 160'd0);
            end
            send(i * 54, 1'b0);
            model_set(i * 54);
            if (i % 16 == 5) send(3488, 1'b1);
            if (i % 16 == 9) send(4095, 1'b1);
        end
        wait_done(w);
        verify_all("run2");

        // Run 3: position 17 twice, 3487 at the very end of the vector.
        model_clear();
        pulse_start();
        send(17, 1'b0);
        send(17, 1'b0);
        send(3487, 1'b0);
        model_set(17);
        model_set(3487);
        for (int j = 1000; j < 1061; j++) begin
            send(j, 1'b0);
            model_set(j);
        end
        step(); step();
        chk("run3_busy_after_64_inputs",  {159'b0, busy},      160'd1);
        chk("run3_ready_after_64_inputs", {159'b0, idx_ready}, 160'd1);
        send(1061, 1'b0);
        model_set(1061);
        wait_done(w);
        verify_all("run3");
        chk("run3_w0_bit142",  {159'b0, got[0][142]},  160'd1);
        chk("run3_w21_bit32",  {159'b0, got[21][32]},  160'd1);
        chk("run3_w21_low",    {128'b0, got[21][31:0]}, 160'd0);

        // Run 4: reset after 10 accepted positions, then a fresh run.
        pulse_start();
        for (int i = 200; i < 210; i++) send(i, 1'b0);
        rst = 1'b1;
        step();
        chk("abort_busy",  {159'b0, busy},      160'd0);
        chk("abort_ready", {159'b0, idx_ready}, 160'd0);
        chk("abort_error", error,               160'd0);
        rst = 1'b0;
        step();
        model_clear();
        pulse_start();
        for (int i = 100; i < 164; i++) begin
            // start while busy must not restart the clear
            if (i == 150) pulse_start();
            send(i, 1'b0);
            model_set(i);
        end
        wait_done(w);
        verify_all("run4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
